// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock,
// carrying between chunks in a register, with valid/ready handshakes on both sides.
module chunked_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   res_s;
    logic             msb_cin_s;
    logic             last_s;

    // Select the current chunk of both operands and add it with the stored carry.
    always_comb begin
        a_chunk_s = {CHUNK{1'b0}};
        b_chunk_s = {CHUNK{1'b0}};
        for (int k = 0; k < N; k++) begin
            a_chunk_s = a_chunk_s | (a_r[k*CHUNK +: CHUNK] & {CHUNK{cnt_r == CW'(k)}});
            b_chunk_s = b_chunk_s | (b_r[k*CHUNK +: CHUNK] & {CHUNK{cnt_r == CW'(k)}});
        end
        res_s     = chunk_add(a_chunk_s, b_chunk_s, carry_r);
        // Carry into the top bit of this chunk; only meaningful on the last chunk.
        msb_cin_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ res_s[CHUNK-1];
        last_s    = (cnt_r == CW'(N - 1));
    end

    // Control FSM, operand capture and chunk-by-chunk result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b ^ {WIDTH{sub}};
                        carry_r    <= cin ^ sub;
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_r == CW'(k)) begin
                            sum_r[k*CHUNK +: CHUNK] <= res_s[CHUNK-1:0];
                        end
                    end
                    carry_r <= res_s[CHUNK];
                    if (last_s) begin
                        cout_r      <= res_s[CHUNK];
                        ovf_r       <= msb_cin_s ^ res_s[CHUNK];
                        cnt_r       <= {CW{1'b0}};
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq: directed cases, backpressure, reset abort,
// and randomized runs on four parameter sets against an arithmetic reference model.
module tb_chunked_adder_seq;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  a0, b0, sum0, a1, b1, sum1, a2, b2, sum2;
    logic [15:0] a3, b3, sum3;
    logic        in_valid_t[4], out_ready_t[4], cin_t[4], sub_t[4];
    logic        in_ready_t[4], out_valid_t[4], cout_t[4], ovf_t[4], busy_t[4];
    logic [15:0] sum_w[4];

    int wd[4] = '{8, 8, 8, 16};
    int nd[4] = '{4, 8, 1, 4};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_adder_seq #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[0]), .in_ready(in_ready_t[0]),
        .a(a0), .b(b0), .cin(cin_t[0]), .sub(sub_t[0]), .out_valid(out_valid_t[0]),
        .out_ready(out_ready_t[0]), .sum(sum0), .cout(cout_t[0]), .ovf(ovf_t[0]), .busy(busy_t[0]));
    chunked_adder_seq #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[1]), .in_ready(in_ready_t[1]),
        .a(a1), .b(b1), .cin(cin_t[1]), .sub(sub_t[1]), .out_valid(out_valid_t[1]),
        .out_ready(out_ready_t[1]), .sum(sum1), .cout(cout_t[1]), .ovf(ovf_t[1]), .busy(busy_t[1]));
    chunked_adder_seq #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[2]), .in_ready(in_ready_t[2]),
        .a(a2), .b(b2), .cin(cin_t[2]), .sub(sub_t[2]), .out_valid(out_valid_t[2]),
        .out_ready(out_ready_t[2]), .sum(sum2), .cout(cout_t[2]), .ovf(ovf_t[2]), .busy(busy_t[2]));
    chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[3]), .in_ready(in_ready_t[3]),
        .a(a3), .b(b3), .cin(cin_t[3]), .sub(sub_t[3]), .out_valid(out_valid_t[3]),
        .out_ready(out_ready_t[3]), .sum(sum3), .cout(cout_t[3]), .ovf(ovf_t[3]), .busy(busy_t[3]));

    assign sum_w[0] = {8'h00, sum0};
    assign sum_w[1] = {8'h00, sum1};
    assign sum_w[2] = {8'h00, sum2};
    assign sum_w[3] = sum3;

    // Reference: unsigned modular sum for sum/cout, true signed sum range test for ovf.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub,
                                  output logic [15:0] s, output logic co, output logic ov);
        longint mask, ua, ub, c, tot, half, sa, sb, st;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = sub ? (~longint'(b)) & mask : longint'(b) & mask;
        c    = (cin ^ sub) ? 1 : 0;
        tot  = ua + ub + c;
        s    = 16'(tot & mask);
        co   = ((tot >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        st   = sa + sb + c;
        ov   = (st >= half) || (st < -half);
    endfunction

    task automatic set_ops(input int d, input logic [15:0] a, input logic [15:0] b);
        case (d)
            0: begin a0 = a[7:0]; b0 = b[7:0]; end
            1: begin a1 = a[7:0]; b1 = b[7:0]; end
            2: begin a2 = a[7:0]; b2 = b[7:0]; end
            default: begin a3 = a; b3 = b; end
        endcase
    endtask

    // Drives one operation from a negedge; returns observed result, latency and handshake status.
    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input int rdelay,
                          output logic [15:0] gs, output logic gc, output logic go,
                          output int lat, output bit stable, output bit released);
        bit acc;
        set_ops(d, a, b);
        cin_t[d] = cin; sub_t[d] = sub; in_valid_t[d] = 1'b1; out_ready_t[d] = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            acc = in_ready_t[d];
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        @(negedge clk);
        in_valid_t[d] = 1'b0;
        set_ops(d, 16'($urandom), 16'($urandom));
        cin_t[d] = 1'($urandom); sub_t[d] = 1'($urandom);
        lat = -1;
        if (acc) begin
            for (int e = 0; e < 40; e++) begin
                if (out_valid_t[d]) begin
                    lat = e;
                    break;
                end
                @(posedge clk); @(negedge clk);
            end
        end
        gs = sum_w[d]; gc = cout_t[d]; go = ovf_t[d];
        stable = 1'b1;
        for (int r = 0; r < rdelay; r++) begin
            @(posedge clk); @(negedge clk);
            if (!out_valid_t[d] || sum_w[d] !== gs || cout_t[d] !== gc || ovf_t[d] !== go ||
                !busy_t[d] || in_ready_t[d]) stable = 1'b0;
        end
        out_ready_t[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready_t[d] = 1'b0;
        released = !out_valid_t[d] && in_ready_t[d] && !busy_t[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (sum_w[d] !== 16'h0000 || out_valid_t[d] !== 1'b0 || busy_t[d] !== 1'b0 ||
                in_ready_t[d] !== 1'b1 || cout_t[d] !== 1'b0 || ovf_t[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: sum=%h ov=%b busy=%b ir=%b cout=%b ovf=%b, want 0 0 0 1 0 0",
                         d, sum_w[d], out_valid_t[d], busy_t[d], in_ready_t[d], cout_t[d], ovf_t[d]);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [7:0] vb[4] = '{8'h33, 8'h01, 8'h20, 8'h01};
        logic       vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] es[4] = '{8'h8D, 8'h01, 8'hF0, 8'h7F};
        logic       ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] gs; logic gc, go; int lat; bit st, rel;
        for (int i = 0; i < 4; i++) begin
            run_op(0, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], vs[i], 1, gs, gc, go, lat, st, rel);
            checks++;
            if (gs !== {8'h00, es[i]} || gc !== ec[i] || go !== eo[i] || lat != 4) begin
                errors++;
                $display("FAIL directed%0d: sum=%h cout=%b ovf=%b lat=%0d, want %h %b %b 4",
                         i, gs, gc, go, lat, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit acc;
        acc = 1'b0;
        set_ops(0, 16'h005A, 16'h0033);
        cin_t[0] = 1'b0; sub_t[0] = 1'b0; in_valid_t[0] = 1'b1; out_ready_t[0] = 1'b0;
        acc = in_ready_t[0];
        @(posedge clk); @(negedge clk);
        set_ops(0, 16'h0010, 16'h0020);
        sub_t[0] = 1'b1;
        lat = -1;
        for (int e = 0; e < 40; e++) begin
            if (out_valid_t[0]) begin lat = e; break; end
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (!acc || lat != 4 || sum_w[0] !== 16'h008D || cout_t[0] !== 1'b0 || ovf_t[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: acc=%b lat=%0d sum=%h cout=%b ovf=%b, want 1 4 8d 0 1",
                     acc, lat, sum_w[0], cout_t[0], ovf_t[0]);
        end
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (!out_valid_t[0] || sum_w[0] !== 16'h008D || cout_t[0] !== 1'b0 || ovf_t[0] !== 1'b1 ||
                in_ready_t[0] !== 1'b0 || busy_t[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b sum=%h ir=%b busy=%b, want 1 8d 0 1",
                         r, out_valid_t[0], sum_w[0], in_ready_t[0], busy_t[0]);
            end
        end
        out_ready_t[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready_t[0] = 1'b0;
        checks++;
        if (out_valid_t[0] !== 1'b0 || in_ready_t[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b, want 0 1", out_valid_t[0], in_ready_t[0]);
        end
        @(posedge clk); @(negedge clk);
        in_valid_t[0] = 1'b0;
        checks++;
        if (busy_t[0] !== 1'b1 || in_ready_t[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept2: busy=%b ir=%b, want 1 0", busy_t[0], in_ready_t[0]);
        end
        lat = -1;
        for (int e = 0; e < 40; e++) begin
            if (out_valid_t[0]) begin lat = e; break; end
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (lat != 4 || sum_w[0] !== 16'h00F0 || cout_t[0] !== 1'b0 || ovf_t[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: lat=%0d sum=%h cout=%b ovf=%b, want 4 f0 0 0",
                     lat, sum_w[0], cout_t[0], ovf_t[0]);
        end
        out_ready_t[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready_t[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] gs; logic gc, go; int lat; bit st, rel, stray;
        set_ops(0, 16'h00FF, 16'h0000);
        cin_t[0] = 1'b0; sub_t[0] = 1'b0; in_valid_t[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_t[0] = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (sum_w[0] !== 16'h0000 || out_valid_t[0] !== 1'b0 || busy_t[0] !== 1'b0 || in_ready_t[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: sum=%h ov=%b busy=%b ir=%b, want 0 0 0 1",
                     sum_w[0], out_valid_t[0], busy_t[0], in_ready_t[0]);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid_t[0]) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_stray: out_valid seen=%b, want 0", stray);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0, gs, gc, go, lat, st, rel);
        checks++;
        if (gs !== 16'h0002 || gc !== 1'b0 || go !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL reset_next: sum=%h cout=%b ovf=%b lat=%0d, want 02 0 0 4", gs, gc, go, lat);
        end
    endtask

    task automatic test_sweep(input int d, input int count);
        logic [15:0] a, b, gs, es; logic cin, sub, gc, go, ec, eo; int lat, gap, rd; bit st, rel;
        for (int i = 0; i < count; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                cin_t[d] = 1'($urandom); sub_t[d] = 1'($urandom);
                @(posedge clk); @(negedge clk);
            end
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            rd = int'($urandom_range(0, 2));
            model(wd[d], a, b, cin, sub, es, ec, eo);
            run_op(d, a, b, cin, sub, rd, gs, gc, go, lat, st, rel);
            checks++;
            if (gs !== es || gc !== ec || go !== eo) begin
                errors++;
                $display("FAIL sweep%0d_result: a=%h b=%h cin=%b sub=%b got %h/%b/%b, want %h/%b/%b",
                         d, a, b, cin, sub, gs, gc, go, es, ec, eo);
            end
            checks++;
            if (lat != nd[d]) begin
                errors++;
                $display("FAIL sweep%0d_latency: got %0d, want %0d", d, lat, nd[d]);
            end
            checks++;
            if (!st || !rel) begin
                errors++;
                $display("FAIL sweep%0d_handshake: stable=%b released=%b, want 1 1", d, st, rel);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            in_valid_t[d] = 1'b0; out_ready_t[d] = 1'b0; cin_t[d] = 1'b0; sub_t[d] = 1'b0;
            set_ops(d, 16'h0000, 16'h0000);
        end
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_sweep(0, 200);
        test_sweep(1, 1000);
        test_sweep(2, 1000);
        test_sweep(3, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the fixed 2-bit gate-level ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, with the carry held in a register between chunks.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths that trade latency for area.
- Adds subtract mode and signed-overflow reporting.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept an operand set
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  1: A - B; 0: A + B
- out_valid  out  1  result held on outputs
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While rst=1: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, chunk counter=0, carry register=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
    - latch a, b^{WIDTH{sub}} and carry=cin^sub;
    - clear counter; go RUN.
  - RUN: in_ready=0. Each edge adds chunk k = bits [k*CHUNK +: CHUNK] of A, effective B and the carry register.
    - The CHUNK-bit result goes into sum[k*CHUNK +: CHUNK]; carry is updated; k increments.
    - On the edge that processes k=N-1: record carry-into-MSB xor carry-out as ovf, record carry-out as cout, go DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready=1 at an edge: go IDLE, out_valid deasserts.
- Latency and throughput:
  - out_valid rises exactly N edges after the acceptance edge.
  - Minimum spacing between accepted operations is N+2 edges; no accept in DONE even if out_ready=1 (no bypass).
- Input sampling:
  - Operands, cin and sub are sampled only at acceptance.
  - Changes on these inputs during RUN or DONE have no effect.
- Output stability:
  - sum/cout/ovf hold their values from the end of RUN until the next acceptance completes its first chunk.
  - They are stable throughout DONE regardless of out_ready.
- Arithmetic:
  - Unsigned modular: {cout,sum} = A + (sub ? ~B : B) + (cin^sub).
  - sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1.
  - ovf = (A[MSB]==Beff[MSB]) && (sum[MSB]!=A[MSB]).
- Degenerate parameters:
  - CHUNK=WIDTH: N=1, single RUN cycle.
  - CHUNK=1: bit-serial.
  - Counter width is clog2(N), minimum 1 bit; the counter never wraps within an operation.
- Reset mid-operation: an assertion in RUN or DONE aborts the operation and applies the reset values above. No out_valid pulse is produced for the aborted operation.
- in_valid while busy: ignored; in_ready=0. Holding in_valid through DONE gives acceptance on the first IDLE edge.

Test Plan:
- WIDTH=8, CHUNK=2: a=0x5A, b=0x33, cin=0, sub=0 -> after 4 edges: out_valid=1, sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, ovf=0.
- Subtract cases:
  - a=0x10, b=0x20, cin=0, sub=1 -> sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles after out_valid, with in_valid=1 carrying a new operand set.
  - Response: sum/cout/ovf stable, in_ready=0, busy=1.
  - Second operand set accepted exactly one edge after the out_ready handshake; its result is correct.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after the 2nd RUN edge.
  - Response: immediately sum=0, out_valid=0, busy=0, in_ready=1; no stray out_valid.
  - The next operation 0x01+0x01 yields 0x02.
- Parameter sweep:
  - Configs: (WIDTH=8, CHUNK=1; latency 8), (WIDTH=8, CHUNK=8; latency 1), (WIDTH=16, CHUNK=4).
  - Stimulus: 1000 random operations with random cin/sub/valid/ready.
  - Response: all results match the golden model and latency equals N.
